// File: rtl/encoder_pwm_mixer.sv
// Quadrature encoder to PWM mixer.
// Each channel decodes a debounced quadrature encoder into an up/down level
// register, and that level drives a PWM output from a shared counter.
// A new level reaches its PWM output only at a period boundary, so a level
// change never produces a runt pulse.
//
// Load interface: load_valid is a single-cycle strobe with no ready. When it
// is high, load_value is written to channel load_chan on that clock edge.
// An out-of-range load_chan drops the strobe.
// If a load and an encoder step reach the same channel on the same edge, the
// load wins.
module encoder_pwm_mixer #(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 8,
  parameter int DB_DIV   = 4,
  parameter int WRAP     = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       enc_a,
  input  logic [CHANNELS-1:0]       enc_b,
  input  logic                      load_valid,
  input  logic [2:0]                load_chan,
  input  logic [WIDTH-1:0]          load_value,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic [CHANNELS*WIDTH-1:0] level
);

  logic [CHANNELS-1:0] a_meta, a_sync, b_meta, b_sync;
  logic [CHANNELS-1:0] db_a, db_b, prev_a, prev_b;
  logic [CHANNELS-1:0] step_up, step_dn, load_hit;
  logic [DB_DIV-1:0]   div_cnt;
  logic                strobe;
  logic                step_due;
  logic [WIDTH-1:0]    pwm_cnt;
  logic                period_start;
  logic [WIDTH-1:0]    level_q [CHANNELS];
  logic [WIDTH-1:0]    level_d [CHANNELS];
  logic [WIDTH-1:0]    duty_q  [CHANNELS];
  logic [WIDTH-1:0]    duty_d  [CHANNELS];

  // Position of an {A,B} pair along the forward sequence 00,01,11,10.
  function automatic logic [1:0] gray_pos(input logic a, input logic b);
    case ({a, b})
      2'b00:   gray_pos = 2'd0;
      2'b01:   gray_pos = 2'd1;
      2'b11:   gray_pos = 2'd2;
      default: gray_pos = 2'd3;
    endcase
  endfunction

  assign strobe       = (div_cnt == '0);
  assign period_start = (pwm_cnt == '0);

  // Per-channel step decode, load match and level output mapping.
  // A position difference of 1 means one step forward.
  // A difference of 3 means one step back.
  // A difference of 0 (no change) or 2 (both pins changed) gives no step.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic [1:0] delta;
    assign delta       = gray_pos(db_a[g], db_b[g]) - gray_pos(prev_a[g], prev_b[g]);
    assign step_up[g]  = step_due && (delta == 2'd1);
    assign step_dn[g]  = step_due && (delta == 2'd3);
    assign load_hit[g] = load_valid && ({1'b0, load_chan} == 4'(g));
    assign level[g*WIDTH +: WIDTH] = level_q[g];
  end

  // Two-flop synchronisers on the raw encoder pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_meta <= '0;
      a_sync <= '0;
      b_meta <= '0;
      b_sync <= '0;
    end else begin
      a_meta <= enc_a;
      a_sync <= a_meta;
      b_meta <= enc_b;
      b_sync <= b_meta;
    end
  end

  // Debounce sampling.
  // On each divider wrap, sample the synchronised pins and keep the previous
  // sample. step_due marks the following cycle, when that pair is decoded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt  <= '0;
      db_a     <= '0;
      db_b     <= '0;
      prev_a   <= '0;
      prev_b   <= '0;
      step_due <= 1'b0;
    end else begin
      div_cnt  <= div_cnt + DB_DIV'(1);
      step_due <= strobe;
      if (strobe) begin
        db_a   <= a_sync;
        db_b   <= b_sync;
        prev_a <= db_a;
        prev_b <= db_b;
      end
    end
  end

  // Next level per channel.
  // Priority: load, then a step up or down. At the limits the level either
  // saturates or wraps, depending on WRAP.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      level_d[i] = level_q[i];
      if (load_hit[i]) begin
        level_d[i] = load_value;
      end else if (step_up[i]) begin
        if (level_q[i] != '1)  level_d[i] = level_q[i] + WIDTH'(1);
        else if (WRAP != 0)    level_d[i] = '0;
      end else if (step_dn[i]) begin
        if (level_q[i] != '0)  level_d[i] = level_q[i] - WIDTH'(1);
        else if (WRAP != 0)    level_d[i] = '1;
      end
    end
  end

  // Duty value in effect for the current PWM count.
  // A new level is taken only at count 0, so a period never changes duty
  // partway through.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      duty_d[i] = period_start ? level_q[i] : duty_q[i];
    end
  end

  // Level, duty and PWM output registers, plus the free-running PWM counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt <= '0;
      pwm_out <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        level_q[i] <= '0;
        duty_q[i]  <= '0;
      end
    end else begin
      pwm_cnt <= pwm_cnt + WIDTH'(1);
      for (int i = 0; i < CHANNELS; i++) begin
        level_q[i] <= level_d[i];
        duty_q[i]  <= duty_d[i];
        pwm_out[i] <= (pwm_cnt < duty_d[i]);
      end
    end
  end

endmodule

// File: tb/tb_encoder_pwm_mixer.sv
// Directed bench for encoder_pwm_mixer.
// Two instances (saturating and wrapping) share all inputs.
module tb_encoder_pwm_mixer;
  localparam int CH = 3;
  localparam int W  = 8;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [CH-1:0]   enc_a = '0;
  logic [CH-1:0]   enc_b = '0;
  logic            load_valid = 1'b0;
  logic [2:0]      load_chan = '0;
  logic [W-1:0]    load_value = '0;
  logic [CH-1:0]   pwm0, pwm1;
  logic [CH*W-1:0] level0, level1;

  int compared   = 0;
  int mismatched = 0;
  int cyc;

  encoder_pwm_mixer #(.CHANNELS(CH), .WIDTH(W), .DB_DIV(4), .WRAP(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b),
    .load_valid(load_valid), .load_chan(load_chan), .load_value(load_value),
    .pwm_out(pwm0), .level(level0)
  );

  encoder_pwm_mixer #(.CHANNELS(CH), .WIDTH(W), .DB_DIV(4), .WRAP(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b),
    .load_valid(load_valid), .load_chan(load_chan), .load_value(load_value),
    .pwm_out(pwm1), .level(level1)
  );

  // Clock and reset.
  // cyc counts clock edges since reset release.
  // After the edge that sets cyc = k, the PWM counter is expected at k mod 256.
  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  function automatic logic [W-1:0] lvl(input logic [CH*W-1:0] v, input int ch);
    return v[ch*W +: W];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_pins(input int ch, input logic [1:0] ab);
    enc_a[ch] = ab[1];
    enc_b[ch] = ab[0];
  endtask

  task automatic do_load(input logic [2:0] ch, input logic [W-1:0] val);
    load_chan  = ch;
    load_value = val;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic count_high(input int ch, input int n, output int hi0, output int hi1);
    hi0 = 0;
    hi1 = 0;
    repeat (n) begin
      @(negedge clk);
      if (pwm0[ch]) hi0++;
      if (pwm1[ch]) hi1++;
    end
  endtask

  // Stop at the negedge just before the edge where the PWM counter reads 'ph'.
  task automatic wait_phase(input int ph);
    bit hit = 0;
    for (int k = 0; k < 300 && !hit; k++) begin
      if (cyc % 256 == ph) hit = 1;
      else @(negedge clk);
    end
    if (!hit) begin
      compared++; mismatched++;
      $display("FAIL wait_phase got timeout want phase %0d", ph);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset_n = 1'b0;
    enc_a = '1;
    enc_b = '1;
    hold(3);
    compared++; if (level0 !== '0) begin mismatched++; $display("FAIL reset_level0 got %h want 0", level0); end
    compared++; if (pwm0 !== '0)   begin mismatched++; $display("FAIL reset_pwm0 got %b want 0", pwm0); end
    compared++; if (level1 !== '0) begin mismatched++; $display("FAIL reset_level1 got %h want 0", level1); end
    compared++; if (pwm1 !== '0)   begin mismatched++; $display("FAIL reset_pwm1 got %b want 0", pwm1); end
    reset_n = 1'b1;
    hold(64);
    compared++; if (level0 !== '0) begin mismatched++; $display("FAIL pins11_after_reset got %h want 0", level0); end
    enc_a = '0;
    enc_b = '0;
    hold(64);
    compared++; if (level0 !== '0) begin mismatched++; $display("FAIL pins11_to_00 got %h want 0", level0); end
    compared++; if (level1 !== '0) begin mismatched++; $display("FAIL pins11_to_00_wrap got %h want 0", level1); end
  endtask

  task automatic test_forward_cycle;
    logic [1:0] seq [4];
    int hi0, hi1;
    seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    for (int s = 0; s < 4; s++) begin
      set_pins(0, seq[s]);
      hold(64);
    end
    compared++; if (lvl(level0, 0) !== 8'd4) begin mismatched++; $display("FAIL fwd_cycle_ch0 got %h want 04", lvl(level0, 0)); end
    compared++; if (lvl(level1, 0) !== 8'd4) begin mismatched++; $display("FAIL fwd_cycle_ch0_wrap got %h want 04", lvl(level1, 0)); end
    wait_phase(0);
    count_high(0, 256, hi0, hi1);
    compared++; if (hi0 != 4) begin mismatched++; $display("FAIL fwd_cycle_pwm_high got %0d want 4", hi0); end
  endtask

  task automatic test_wrap_saturate;
    logic [1:0] fwd [3];
    logic [1:0] rev [3];
    fwd = '{2'b01, 2'b11, 2'b10};
    rev = '{2'b11, 2'b01, 2'b00};
    do_load(3'd1, 8'hFE);
    compared++; if (lvl(level0, 1) !== 8'hFE) begin mismatched++; $display("FAIL load_ch1 got %h want fe", lvl(level0, 1)); end
    for (int s = 0; s < 3; s++) begin
      set_pins(1, fwd[s]);
      hold(64);
    end
    compared++; if (lvl(level0, 1) !== 8'hFF) begin mismatched++; $display("FAIL sat_up got %h want ff", lvl(level0, 1)); end
    compared++; if (lvl(level1, 1) !== 8'h01) begin mismatched++; $display("FAIL wrap_up got %h want 01", lvl(level1, 1)); end
    do_load(3'd1, 8'h01);
    for (int s = 0; s < 3; s++) begin
      set_pins(1, rev[s]);
      hold(64);
    end
    compared++; if (lvl(level0, 1) !== 8'h00) begin mismatched++; $display("FAIL sat_down got %h want 00", lvl(level0, 1)); end
    compared++; if (lvl(level1, 1) !== 8'hFE) begin mismatched++; $display("FAIL wrap_down got %h want fe", lvl(level1, 1)); end
  endtask

  // Find the step-apply edge from a ch0 step.
  // Then line up a ch2 load with the next step edge, where ch0 and ch2 both
  // step.
  task automatic test_load_collision;
    bit seen = 0;
    set_pins(0, 2'b01);
    for (int k = 0; k < 64 && !seen; k++) begin
      @(negedge clk);
      if (lvl(level0, 0) !== 8'd4) seen = 1;
    end
    compared++; if (!seen || lvl(level0, 0) !== 8'd5) begin mismatched++; $display("FAIL step_edge_ch0 got %h want 05", lvl(level0, 0)); end
    set_pins(0, 2'b11);
    set_pins(2, 2'b01);
    hold(15);
    do_load(3'd2, 8'h80);
    compared++; if (lvl(level0, 2) !== 8'h80) begin mismatched++; $display("FAIL collide_ch2 got %h want 80", lvl(level0, 2)); end
    compared++; if (lvl(level0, 0) !== 8'd6)  begin mismatched++; $display("FAIL collide_ch0 got %h want 06", lvl(level0, 0)); end
    compared++; if (lvl(level1, 2) !== 8'h80) begin mismatched++; $display("FAIL collide_ch2_wrap got %h want 80", lvl(level1, 2)); end
    do_load(3'd5, 8'h33);
    @(negedge clk);
    compared++; if (level0 !== {8'h80, 8'h00, 8'h06}) begin mismatched++; $display("FAIL bad_chan got %h want 800006", level0); end
    compared++; if (level1 !== {8'h80, 8'hFE, 8'h06}) begin mismatched++; $display("FAIL bad_chan_wrap got %h want 80fe06", level1); end
  endtask

  task automatic test_glitch;
    enc_a[2] = 1'b1;
    hold(3);
    enc_a[2] = 1'b0;
    hold(64);
    compared++; if (level0 !== {8'h80, 8'h00, 8'h06}) begin mismatched++; $display("FAIL glitch got %h want 800006", level0); end
    set_pins(2, 2'b10);
    set_pins(1, 2'b11);
    hold(64);
    compared++; if (level0 !== {8'h80, 8'h00, 8'h06}) begin mismatched++; $display("FAIL both_toggle got %h want 800006", level0); end
    compared++; if (level1 !== {8'h80, 8'hFE, 8'h06}) begin mismatched++; $display("FAIL both_toggle_wrap got %h want 80fe06", level1); end
  endtask

  task automatic test_pwm_duty;
    int hi0, hi1;
    do_load(3'd1, 8'h10);
    wait_phase(0);
    hi0 = 0;
    for (int k = 0; k < 256; k++) begin
      if (k == 100) begin
        load_chan = 3'd1; load_value = 8'hF0; load_valid = 1'b1;
      end
      if (k == 101) load_valid = 1'b0;
      @(negedge clk);
      if (pwm0[1]) hi0++;
    end
    compared++; if (hi0 != 16) begin mismatched++; $display("FAIL midperiod_old_duty got %0d want 16", hi0); end
    count_high(1, 256, hi0, hi1);
    compared++; if (hi0 != 240) begin mismatched++; $display("FAIL midperiod_new_duty got %0d want 240", hi0); end
    do_load(3'd1, 8'hFF);
    wait_phase(0);
    count_high(1, 256, hi0, hi1);
    compared++; if (hi0 != 255) begin mismatched++; $display("FAIL duty_ff got %0d want 255", hi0); end
    compared++; if (hi1 != 255) begin mismatched++; $display("FAIL duty_ff_wrap got %0d want 255", hi1); end
    do_load(3'd1, 8'h00);
    wait_phase(0);
    count_high(1, 256, hi0, hi1);
    compared++; if (hi0 != 0) begin mismatched++; $display("FAIL duty_zero got %0d want 0", hi0); end
  endtask

  task automatic test_reset_midperiod;
    int hi;
    do_load(3'd0, 8'h55);
    hold(1);
    wait_phase(0);
    hold(1);
    wait_phase(10);
    compared++; if (pwm0[0] !== 1'b1) begin mismatched++; $display("FAIL pre_reset_pwm got %b want 1", pwm0[0]); end
    compared++; if (lvl(level0, 0) !== 8'h55) begin mismatched++; $display("FAIL pre_reset_level got %h want 55", lvl(level0, 0)); end
    #2;
    reset_n = 1'b0;
    enc_a = '0;
    enc_b = '0;
    #1;
    compared++; if (level0 !== '0) begin mismatched++; $display("FAIL async_reset_level got %h want 0", level0); end
    compared++; if (pwm0 !== '0)   begin mismatched++; $display("FAIL async_reset_pwm got %b want 0", pwm0); end
    compared++; if (level1 !== '0) begin mismatched++; $display("FAIL async_reset_level_wrap got %h want 0", level1); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_load(3'd0, 8'h02);
    compared++; if (lvl(level0, 0) !== 8'h02) begin mismatched++; $display("FAIL post_reset_load got %h want 02", lvl(level0, 0)); end
    hi = 0;
    for (int k = 0; k < 300 && cyc < 256; k++) begin
      @(negedge clk);
      if (pwm0[0]) hi++;
    end
    compared++; if (hi != 0 || cyc != 256) begin mismatched++; $display("FAIL restart_first_period got %0d highs at cyc %0d want 0 at 256", hi, cyc); end
    @(negedge clk);
    compared++; if (pwm0[0] !== 1'b1) begin mismatched++; $display("FAIL restart_cnt0 got %b want 1", pwm0[0]); end
    @(negedge clk);
    compared++; if (pwm0[0] !== 1'b1) begin mismatched++; $display("FAIL restart_cnt1 got %b want 1", pwm0[0]); end
    @(negedge clk);
    compared++; if (pwm0[0] !== 1'b0) begin mismatched++; $display("FAIL restart_cnt2 got %b want 0", pwm0[0]); end
  endtask

  initial begin
    test_reset();
    test_forward_cycle();
    test_wrap_saturate();
    test_load_collision();
    test_glitch();
    test_pwm_duty();
    test_reset_midperiod();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
